// File: rtl/calendar_pkg.sv
// Shared types and constants for the calendar time-set controller.
package calendar_pkg;

  localparam int unsigned TIME_W = 6;

  localparam logic [TIME_W-1:0] HOURS_MAX = 6'd23;
  localparam logic [TIME_W-1:0] MINS_MAX  = 6'd59;
  localparam logic [TIME_W-1:0] SECS_MAX  = 6'd59;

  typedef enum logic [2:0] {
    RUN,
    SET_H,
    SET_M,
    SET_S,
    COMMIT
  } state_e;

  // Wraps only on exact equality; out-of-range values simply step upward.
  function automatic logic [TIME_W-1:0] inc_wrap(input logic [TIME_W-1:0] v,
                                                 input logic [TIME_W-1:0] max_v);
    return (v == max_v) ? '0 : v + TIME_W'(1);
  endfunction

endpackage

// File: rtl/calendar_prescaler.sv
// One-second prescaler: registered TICK after the wrap count, plus half-period
// strobe used to pace the set-mode blink.
module calendar_prescaler #(
  parameter int unsigned TICK_DIV = 1000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic tick_en_i,
  output logic tick_o,
  output logic half_o
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2 - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_TOP);

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || wrap) cnt_d = '0;
  end

  assign tick_d = tick_en_i && !clr_i && wrap;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;
  assign half_o = wrap || (cnt_q == CNT_HALF);

endmodule

// File: rtl/calendar_set_ctrl.sv
// Time-set controller: run-mode TICK generation, shadow-field editing with
// idle timeout, and a single-cycle LOAD commit to the calendar counter.
module calendar_set_ctrl
  import calendar_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1000,
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              MODE_BTN,
  input  logic              INC_BTN,
  input  logic [TIME_W-1:0] CUR_HOURS,
  input  logic [TIME_W-1:0] CUR_MINS,
  input  logic [TIME_W-1:0] CUR_SECS,
  output logic              TICK,
  output logic              LOAD,
  output logic [TIME_W-1:0] LD_HOURS,
  output logic [TIME_W-1:0] LD_MINS,
  output logic [TIME_W-1:0] LD_SECS,
  output logic [1:0]        SET_FIELD,
  output logic              BLINK
);

  localparam int unsigned IDLE_LIMIT = TIMEOUT_S * TICK_DIV;
  localparam int unsigned IDLE_W     = $clog2(IDLE_LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_LIMIT - 1);

  state_e            state_q, state_d;
  logic [TIME_W-1:0] hrs_q, hrs_d, min_q, min_d, sec_q, sec_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              load_q, load_d;
  logic              blink_q, blink_d;
  logic              in_set, timeout, half, pre_clr;

  // The prescaler keeps running in set states to pace BLINK; only TICK is gated.
  assign pre_clr = (state_q == RUN && MODE_BTN) || (state_q == COMMIT) || timeout;

  calendar_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk_i     (CLK),
    .rst_ni    (RST_N),
    .clr_i     (pre_clr),
    .tick_en_i (state_q == RUN),
    .tick_o    (TICK),
    .half_o    (half)
  );

  assign in_set = (state_q == SET_H) || (state_q == SET_M) || (state_q == SET_S);

  always_comb begin
    state_d = state_q;
    hrs_d   = hrs_q;
    min_d   = min_q;
    sec_d   = sec_q;
    idle_d  = '0;
    timeout = 1'b0;
    blink_d = 1'b0;

    unique case (state_q)
      RUN: begin
        if (MODE_BTN) begin
          state_d = SET_H;
          hrs_d   = CUR_HOURS;
          min_d   = CUR_MINS;
          sec_d   = CUR_SECS;
        end
      end
      SET_H: begin
        if (MODE_BTN)     state_d = SET_M;
        else if (INC_BTN) hrs_d = inc_wrap(hrs_q, HOURS_MAX);
      end
      SET_M: begin
        if (MODE_BTN)     state_d = SET_S;
        else if (INC_BTN) min_d = inc_wrap(min_q, MINS_MAX);
      end
      SET_S: begin
        if (MODE_BTN)     state_d = COMMIT;
        else if (INC_BTN) sec_d = inc_wrap(sec_q, SECS_MAX);
      end
      COMMIT:  state_d = RUN;
      default: state_d = RUN;
    endcase

    if (in_set && !MODE_BTN && !INC_BTN) begin
      if (idle_q == IDLE_LAST) begin
        timeout = 1'b1;
        state_d = RUN;
      end else begin
        idle_d = idle_q + IDLE_W'(1);
      end
    end

    if ((state_d == SET_H) || (state_d == SET_M) || (state_d == SET_S)) begin
      if (state_q == RUN) blink_d = 1'b1;
      else                blink_d = half ? ~blink_q : blink_q;
    end

    load_d = (state_d == COMMIT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RUN;
      hrs_q   <= '0;
      min_q   <= '0;
      sec_q   <= '0;
      idle_q  <= '0;
      load_q  <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hrs_q   <= hrs_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      idle_q  <= idle_d;
      load_q  <= load_d;
      blink_q <= blink_d;
    end
  end

  always_comb begin
    unique case (state_q)
      SET_H:   SET_FIELD = 2'd1;
      SET_M:   SET_FIELD = 2'd2;
      SET_S:   SET_FIELD = 2'd3;
      default: SET_FIELD = 2'd0;
    endcase
  end

  assign LOAD     = load_q;
  assign BLINK    = blink_q;
  assign LD_HOURS = hrs_q;
  assign LD_MINS  = min_q;
  assign LD_SECS  = sec_q;

endmodule
